i2c_req_arbiter: RTL
====================

Name: i2c_req_arbiter

Overview:
Shares one I2C byte-transaction master among NUM_REQ independent requesters. It arbitrates round-robin, launches one single-byte transaction at a time on the master's addr/data_in/rw/enable inputs, and tracks the master's ready through start and completion. It returns read data with a one-cycle done pulse to the winning requester. It sits between system-side clients (sensor pollers, config loaders) and the I2C controller, in the same clk domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 64, clk cycles allowed for m_ready to fall after enable is raised (>=4)
IDX_W, $clog2(NUM_REQ), width of requester index (derived, not overridden)

Ports:
clk  in  1  system clock; the I2C master runs from the same clk
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request; held high until its done pulse
req_addr  in  7*NUM_REQ  7-bit target address, requester i at [7i+6:7i]
req_rw  in  NUM_REQ  1=read, 0=write
req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i]
done  out  NUM_REQ  one-cycle completion pulse, one-hot
err  out  1  valid with done; 1 = launch timeout, no transaction ran
rdata  out  8  read byte, valid with done when rw=1; held until next done
busy  out  1  high in any state other than IDLE
grant_idx  out  IDX_W  index of current or last winner
m_addr  out  7  to master addr
m_rw  out  1  to master rw
m_data_in  out  8  to master data_in
m_enable  out  1  to master enable
m_ready  in  1  from master ready (high = master idle)
m_data_out  in  8  from master data_out

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE. m_enable, m_addr, m_rw, m_data_in, done, err, rdata and grant_idx = 0. Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, LAUNCH, BUSY, DONE.
- IDLE: if |req and m_ready=1, select winner w = first set req bit searching cyclically from last+1.
  - Register grant_idx<=w, m_addr<=req_addr[w], m_rw<=req_rw[w], m_data_in<=req_wdata[w], m_enable<=1.
  - Clear timer, go to LAUNCH.
  - If m_ready=0 (master still finishing), stay in IDLE.
- LAUNCH: hold m_enable=1 and the m_* fields stable; timer increments each cycle.
  - m_ready=0 observed: m_enable<=0, go to BUSY.
  - Otherwise, if timer==TIMEOUT-1: m_enable<=0, err<=1, done[w]<=1, go to DONE (rdata unchanged).
  - m_ready falling on the timeout cycle takes the BUSY path (no error).
- BUSY: wait for m_ready=1. Then rdata<=(m_rw ? m_data_out : rdata), done[w]<=1, err<=0, go to DONE. There is no timeout in BUSY, because the master always returns to idle.
- DONE: done/err are visible for exactly this cycle. Update last<=w, clear done/err, go to IDLE.
  - Requester must drop req on the edge after done. If req is still high in IDLE, it counts as a new request.
- A requester deasserting req mid-transaction is ignored; the transaction completes and done still pulses.
- Latency: done arrives at least 3 cycles after req is sampled in IDLE, plus the master transaction time.
- m_* outputs keep their last values outside LAUNCH; only m_enable gates the master.
- Reset mid-operation: returns to reset state immediately and no done is issued; the master has its own reset.

Decomposition:
- Shared package i2c_pkg: state encoding constants, ADDR_W=7, DATA_W=8, and a helper for the round-robin index search.
- One sub-module, rr_arbiter (NUM_REQ): purely combinational winner select from req and last, outputting valid and idx.
- i2c_req_arbiter instantiates rr_arbiter; the FSM, timer and registers live in the top.

Test Plan:
- Write from requester 0 (addr 0x50, rw=0, wdata 0x3C), stub master drops ready 2 cycles after enable and holds it low 20 cycles -> m_addr=0x50, m_data_in=0x3C, single done[0] pulse, err=0, rdata unchanged.
- Read from requester 2 (addr 0x68, rw=1), stub returns 0xA5 -> done[2] pulse, rdata=0xA5, grant_idx=2.
- req=4'b0101 asserted together after reset -> requester 0 served first, then requester 2, with exactly two done pulses.
- All four req held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- m_ready stuck high, req[1] raised -> m_enable high for exactly 64 cycles, then done[1]=1 with err=1, m_enable=0.
- rst_n pulsed low during BUSY -> all outputs 0 asynchronously; after release, a new req[3] is served normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiter: field widths, FSM
// state encoding and the round-robin winner search.
package i2c_pkg;

    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Returns {valid, idx[2:0]}: the first set bit of req searching
    // cyclically from last+1 over n requesters. The loop runs downwards so
    // the nearest candidate is written last and wins.
    function automatic logic [3:0] rr_search(input logic [MAX_REQ-1:0] req,
                                             input int n,
                                             input int last);
        logic [3:0] res;
        int         c;
        res = 4'd0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                c = (last + k) % n;
                if (req[c[2:0]]) begin
                    res = {1'b1, c[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select over NUM_REQ requesters,
// starting the search just after the previous winner.
module rr_arbiter
    import i2c_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [MAX_REQ-1:0] w_req8;
    logic [3:0]         w_pick;

    // Zero-extend the request vector to the width the search helper takes.
    always_comb begin
        w_req8                = '0;
        w_req8[NUM_REQ-1:0]   = i_req;
    end

    assign w_pick  = rr_search(w_req8, NUM_REQ, int'(i_last));
    assign o_valid = w_pick[3];
    assign o_idx   = IDX_W'(w_pick[2:0]);

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one single-byte I2C master between NUM_REQ requesters.
//
// Handshake: a requester raises i_req[i] with its addr/rw/wdata stable and
// holds it until o_done[i] pulses for one cycle; it drops i_req[i] on the
// edge after that pulse. o_err and o_rdata are valid in the o_done cycle.
// Toward the master, o_m_enable is held high with stable o_m_* fields until
// i_m_ready falls (accepted) or TIMEOUT cycles pass (launch error).
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int TIMEOUT = 64,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [NUM_REQ-1:0]        i_req_rw,
    input  logic [DATA_W*NUM_REQ-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]        o_done,
    output logic                      o_err,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic [IDX_W-1:0]          o_grant_idx,
    output logic [ADDR_W-1:0]         o_m_addr,
    output logic                      o_m_rw,
    output logic [DATA_W-1:0]         o_m_data_in,
    output logic                      o_m_enable,
    input  logic                      i_m_ready,
    input  logic [DATA_W-1:0]         i_m_data_out,
    output state_t                    o_dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t              r_state,  w_state_n;
    logic [IDX_W-1:0]    r_last,   w_last_n;
    logic [IDX_W-1:0]    r_grant,  w_grant_n;
    logic [TMR_W-1:0]    r_timer,  w_timer_n;
    logic [ADDR_W-1:0]   r_addr,   w_addr_n;
    logic                r_rw,     w_rw_n;
    logic [DATA_W-1:0]   r_wdata,  w_wdata_n;
    logic                r_enable, w_enable_n;
    logic [NUM_REQ-1:0]  r_done,   w_done_n;
    logic                r_err,    w_err_n;
    logic [DATA_W-1:0]   r_rdata,  w_rdata_n;

    logic                w_valid;
    logic [IDX_W-1:0]    w_idx;
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];

    // Unpack the flat per-requester buses so the winner can index them.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = i_req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = i_req_wdata[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (i_req),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // State and datapath registers; reset leaves requester 0 on top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_last   <= IDX_W'(NUM_REQ-1);
            r_grant  <= '0;
            r_timer  <= '0;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_enable <= 1'b0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_last   <= w_last_n;
            r_grant  <= w_grant_n;
            r_timer  <= w_timer_n;
            r_addr   <= w_addr_n;
            r_rw     <= w_rw_n;
            r_wdata  <= w_wdata_n;
            r_enable <= w_enable_n;
            r_done   <= w_done_n;
            r_err    <= w_err_n;
            r_rdata  <= w_rdata_n;
        end
    end

    // Next-state and next-register values; everything holds unless a state moves it.
    always_comb begin
        w_state_n  = r_state;
        w_last_n   = r_last;
        w_grant_n  = r_grant;
        w_timer_n  = r_timer;
        w_addr_n   = r_addr;
        w_rw_n     = r_rw;
        w_wdata_n  = r_wdata;
        w_enable_n = r_enable;
        w_done_n   = r_done;
        w_err_n    = r_err;
        w_rdata_n  = r_rdata;
        case (r_state)
            ST_IDLE: begin
                // A low ready here means the master is still winding down.
                if (w_valid && i_m_ready) begin
                    w_grant_n  = w_idx;
                    w_addr_n   = w_addr_arr[w_idx];
                    w_rw_n     = i_req_rw[w_idx];
                    w_wdata_n  = w_wdata_arr[w_idx];
                    w_enable_n = 1'b1;
                    w_timer_n  = '0;
                    w_state_n  = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_timer_n = r_timer + 1'b1;
                if (!i_m_ready) begin
                    w_enable_n = 1'b0;
                    w_state_n  = ST_BUSY;
                end else if (r_timer == TMR_W'(TIMEOUT-1)) begin
                    w_enable_n         = 1'b0;
                    w_err_n            = 1'b1;
                    w_done_n           = '0;
                    w_done_n[r_grant]  = 1'b1;
                    w_state_n          = ST_DONE;
                end
            end
            ST_BUSY: begin
                // The master always returns to idle, so no timeout here.
                if (i_m_ready) begin
                    w_rdata_n          = r_rw ? i_m_data_out : r_rdata;
                    w_done_n           = '0;
                    w_done_n[r_grant]  = 1'b1;
                    w_err_n            = 1'b0;
                    w_state_n          = ST_DONE;
                end
            end
            ST_DONE: begin
                w_last_n  = r_grant;
                w_done_n  = '0;
                w_err_n   = 1'b0;
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_grant_idx = r_grant;
    assign o_m_addr    = r_addr;
    assign o_m_rw      = r_rw;
    assign o_m_data_in = r_wdata;
    assign o_m_enable  = r_enable;
    assign o_dbg_state = r_state;

endmodule
